max: RTL and testbench
======================

// Module: max
//
// PURPOSE
// - Argmax selector: takes NUM_IN signed two's-complement words packed into one bus.
// - Returns the 4-bit position (0..NUM_IN-1) of the largest word.
// - Used by the classifier back end to pick the winning output neuron from its 10 scores.
// - Combinational compare tree feeding one output register; latency 1 clock.
//
// PARAMETERS
// - NUM_IN  10  number of packed input words
// - WIDTH   26  bits per word, signed two's complement
// - IDX_W   4   index width; must satisfy 2**IDX_W >= NUM_IN
//
// PORTS
// - clk          in   1                 rising-edge clock; single clock domain
// - GlobalReset  in   1                 synchronous, active-high reset
// - Num          in   NUM_IN*WIDTH      word k = Num[k*WIDTH +: WIDTH], signed
// - Index        out  IDX_W             registered position of the maximum word
//
// BEHAVIOUR
// - All compares are signed. Word 0x3FFFFFF is -1 and is less than 0.
// - Inputs carry no handshake or valid; Num is sampled every clock edge.
// - At each posedge clk:
//   - GlobalReset=1: Index <= 0. Reset wins over any Num value.
//   - Otherwise: Index <= argmax(Num as presented before that edge).
// - Latency: a Num change appears on Index after exactly one rising edge.
//   - Index is never combinational from Num.
//   - No extra pipeline stages.
// - Ties: the lowest index wins.
//   - Every compare node puts its lower-index operand on the left.
//   - Left wins unless right > left (strictly greater).
// - Reset mid-operation: Index returns to 0 on the reset edge.
//   - The first edge after reset deasserts loads the argmax of current Num.
// - Extremes: most-negative (-2**25) and most-positive (2**25-1) words compare correctly.
//   - No overflow; compare only, no subtraction widening.
// - Index never takes a value >= NUM_IN.
//
// STRUCTURE
// - Shared package: WIDTH, NUM_IN, IDX_W constants.
//   - Typedef for the (signed value, index) pair carried through the tree.
// - Sub-module max_cmp2: combinational two-input stage.
//   - Inputs: (valA, idxA), (valB, idxB), A = lower index.
//   - Output: (valB, idxB) if valB > valA (signed), else (valA, idxA).
// - Top level:
//   - Unpacks Num with a generate loop.
//   - Tree for NUM_IN=10: 10 -> 5 -> 3 -> 2 -> 1 (odd entry passes through).
//   - One IDX_W-bit register with the synchronous reset.
//
// TESTING
// - Reset: GlobalReset=1 for 2 edges with any Num -> Index=0 after each edge.
// - Mixed values: Num = {-10,-15,-2,-100,-30,-10000,200,-301234,-10000,-69} (word0 first).
//   - Before the next edge Index still holds its old value.
//   - After one edge Index=6.
// - All negative: {-5,-9,-1,-7,-3,-8,-6,-4,-2,-10} -> Index=2.
// - Ties:
//   - All words = 42 -> Index=0.
//   - Words 3 and 8 both = 2**25-1, the rest 0 -> Index=3.
// - Extremes: word9 = 2**25-1, all others -2**25 -> Index=9.
//   - Then word0 = 2**25-1 too -> Index=0.
// - Reset mid-stream: Index=6, assert GlobalReset one edge -> 0.
//   - Deassert -> Index=6 on the next edge.
//   - Change Num to max at word 4 -> Index=4 exactly one edge later.

Source files
------------

// File: rtl/max_pkg.sv
// Shared constants and the (value, index) candidate type for the argmax tree.
package max_pkg;

    localparam int unsigned NUM_IN = 10;
    localparam int unsigned WIDTH  = 26;
    localparam int unsigned IDX_W  = 4;

    typedef struct packed {
        logic signed [WIDTH-1:0] val;
        logic [IDX_W-1:0]        idx;
    } cand_t;

    // a must be the lower-index operand: it keeps the win unless b is strictly greater.
    function automatic cand_t pick(input cand_t a, input cand_t b);
        return ($signed(b.val) > $signed(a.val)) ? b : a;
    endfunction

endpackage

// File: rtl/max_if.sv
// Packed score bus in, registered winner index out.
interface max_if;
    import max_pkg::*;

    logic [NUM_IN*WIDTH-1:0] Num;
    logic [IDX_W-1:0]        Index;

    modport master (output Num, input Index);
    modport slave  (input Num, output Index);

endinterface

// File: rtl/max_cmp2.sv
// Two-input compare node of the argmax tree; operand a carries the lower index.
module max_cmp2
    import max_pkg::*;
(
    input  cand_t a,
    input  cand_t b,
    output cand_t y
);

    assign y = pick(a, b);

endmodule

// File: rtl/max.sv
// Argmax over NUM_IN signed words: combinational compare tree into one index register.
module max
    import max_pkg::*;
(
    input  logic  clk,
    input  logic  GlobalReset,
    max_if.slave  bus
);

    cand_t            l0 [NUM_IN];
    cand_t            l1 [5];
    cand_t            l2 [3];
    cand_t            l3 [2];
    logic [IDX_W-1:0] win_idx;

    for (genvar k = 0; k < NUM_IN; k++) begin : g_unpack
        assign l0[k].val = bus.Num[k*WIDTH +: WIDTH];
        assign l0[k].idx = IDX_W'(k);
    end

    for (genvar j = 0; j < 5; j++) begin : g_l1
        max_cmp2 u_cmp (.a(l0[2*j]), .b(l0[2*j+1]), .y(l1[j]));
    end

    max_cmp2 u_l2_0 (.a(l1[0]), .b(l1[1]), .y(l2[0]));
    max_cmp2 u_l2_1 (.a(l1[2]), .b(l1[3]), .y(l2[1]));
    assign l2[2] = l1[4];

    max_cmp2 u_l3_0 (.a(l2[0]), .b(l2[1]), .y(l3[0]));
    assign l3[1] = l2[2];

    // Last node needs only the index, so it uses the compare function directly.
    assign win_idx = pick(l3[0], l3[1]).idx;

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            bus.Index <= '0;
        end else begin
            bus.Index <= win_idx;
        end
    end

endmodule

// File: tb/tb_max.sv
// Directed bench for the argmax selector with hand-computed expected indices.
module tb_max;
    import max_pkg::*;

    localparam int MAXV = 33554431;
    localparam int MINV = -33554432;

    logic clk;
    logic rst;
    int   words [NUM_IN];
    int   total;
    int   bad;

    max_if bus ();

    max dut (
        .clk         (clk),
        .GlobalReset (rst),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive();
        for (int k = 0; k < NUM_IN; k++) begin
            bus.Num[k*WIDTH +: WIDTH] = WIDTH'(words[k]);
        end
    endtask

    task automatic fill(input int v);
        for (int k = 0; k < NUM_IN; k++) words[k] = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int exp);
        int got;
        got = int'(bus.Index);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: Index=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic set_mixed();
        words = '{-10, -15, -2, -100, -30, -10000, 200, -301234, -10000, -69};
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        for (int k = 0; k < NUM_IN; k++) words[k] = int'($urandom);
        drive();

        // Reset wins over arbitrary Num on consecutive edges.
        tick();
        check("reset_edge1", 0);
        fill(0);
        words[7] = 1234;
        drive();
        tick();
        check("reset_edge2", 0);

        rst = 1'b0;
        set_mixed();
        drive();
        #2;
        check("mixed_before_edge", 0);
        tick();
        check("mixed", 6);

        words = '{-5, -9, -1, -7, -3, -8, -6, -4, -2, -10};
        drive();
        tick();
        check("all_negative", 2);

        fill(-1);
        words[5] = 0;
        drive();
        tick();
        check("zero_beats_minus1", 5);

        fill(42);
        drive();
        tick();
        check("tie_all_42", 0);

        fill(0);
        words[3] = MAXV;
        words[8] = MAXV;
        drive();
        tick();
        check("tie_max_3_8", 3);

        fill(MINV);
        words[9] = MAXV;
        drive();
        tick();
        check("extreme_word9", 9);

        words[0] = MAXV;
        drive();
        tick();
        check("extreme_tie_0_9", 0);

        fill(MINV);
        words[6] = MINV + 1;
        drive();
        tick();
        check("near_min", 6);

        // Reset in the middle of operation, then recovery.
        set_mixed();
        drive();
        tick();
        check("midstream_pre", 6);
        rst = 1'b1;
        tick();
        check("midstream_reset", 0);
        rst = 1'b0;
        tick();
        check("midstream_recover", 6);
        words[4] = 1000;
        drive();
        #2;
        check("word4_before_edge", 6);
        tick();
        check("word4_after_edge", 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
